clk_mask_monitor: RTL and testbench

- Receive-side companion to the clock-mask generator. Watches a clk_mask strobe stream, measures the cycles between strobes, and locks onto a stable period.
- Once locked, it predicts each expected strobe and flags missing, early or late strobes.
- Sits beside any masked sub-domain (PPU, audio, CPU-slow path) as a health and phase monitor.
- Its outputs feed debug registers and drive `mask_expected` for logic that must prepare one cycle before a masked edge.

---
 rtl/clk_mask_monitor.sv | 144 ++++++++++++++
 tb/tb_clk_mask_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/clk_mask_monitor.sv
// Receive-side monitor for a clk_mask strobe stream: locks onto a stable strobe
// period, predicts each strobe and flags missing/early ones. Optional err_count: CLK_MASK_MONITOR_ERRCNT_EN.
module clk_mask_monitor #(
    parameter  int MAX_PERIOD = 64,
    parameter  int LOCK_COUNT = 4,
    localparam int W          = $clog2(MAX_PERIOD) + 1
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         clk_mask,
    output logic [W-1:0] period,
    output logic         locked,
    output logic         mask_expected,
`ifdef CLK_MASK_MONITOR_ERRCNT_EN
    output logic [7:0]   err_count,
`endif
    output logic         error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_CNT   = W'(MAX_PERIOD);
    localparam logic [3:0]   LOCK_MTCH = 4'(LOCK_COUNT);

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] candidate, candidate_n;
    logic [3:0]   match, match_n;
    logic [W-1:0] period_n;
    logic         locked_n;
    logic         error_n;
    logic [W-1:0] measured;

    assign measured      = cnt + 1'b1;
    assign mask_expected = locked && (cnt == period - 1'b1);

    // NOTE: all next-state values get a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        candidate_n = candidate;
        match_n     = match;
        period_n    = period;
        locked_n    = locked;
        error_n     = 1'b0;

        if (clk_mask)
            cnt_n = '0;
        else if (cnt == MAX_CNT)
            cnt_n = MAX_CNT;
        else
            cnt_n = cnt + 1'b1;

        unique case (state)
            IDLE: begin
                if (clk_mask) begin
                    state_n     = ACQUIRE;
                    candidate_n = '0;
                    match_n     = '0;
                end
            end

            ACQUIRE: begin
                if (clk_mask) begin
                    if (cnt == MAX_CNT) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        if (measured == candidate) begin
                            match_n = match + 1'b1;
                        end else begin
                            candidate_n = measured;
                            match_n     = 4'd1;
                        end
                        if (match_n == LOCK_MTCH) begin
                            state_n  = LOCKED;
                            period_n = candidate_n;
                            locked_n = 1'b1;
                        end
                    end
                end else if (cnt_n == MAX_CNT) begin
                    // Gap longer than any acceptable period: give up acquisition.
                    error_n = 1'b1;
                    state_n = IDLE;
                end
            end

            LOCKED: begin
                if (clk_mask && !mask_expected) begin
                    error_n     = 1'b1;
                    locked_n    = 1'b0;
                    state_n     = ACQUIRE;
                    candidate_n = measured;
                    match_n     = 4'd1;
                end else if (!clk_mask && mask_expected) begin
                    error_n  = 1'b1;
                    locked_n = 1'b0;
                    state_n  = IDLE;
                end
            end

            default: begin
                state_n  = IDLE;
                locked_n = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            candidate <= '0;
            match     <= '0;
            period    <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            candidate <= candidate_n;
            match     <= match_n;
            period    <= period_n;
            locked    <= locked_n;
            error     <= error_n;
        end
    end

`ifdef CLK_MASK_MONITOR_ERRCNT_EN
    // Counts alongside the error pulse; only rst clears it, relock does not.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (error_n && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_clk_mask_monitor.sv
// Directed self-checking bench for clk_mask_monitor (default MAX_PERIOD=64, LOCK_COUNT=4).
module tb_clk_mask_monitor;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       clk_mask;
    logic [6:0] period;
    logic       locked;
    logic       mask_expected;
    logic       error;
`ifdef CLK_MASK_MONITOR_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    clk_mask_monitor dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .clk_mask      (clk_mask),
        .period        (period),
        .locked        (locked),
        .mask_expected (mask_expected),
`ifdef CLK_MASK_MONITOR_ERRCNT_EN
        .err_count     (err_count),
`endif
        .error         (error)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one strobe value for one clock, then sample just after the edge.
    task automatic drive(input logic m);
        clk_mask = m;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        clk_mask = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic m;

        // Reset state
        do_reset();
        check("rst_period", 32'(period), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mexp", 32'(mask_expected), 32'd0);

        // Period 4 lock on the 5th strobe (edge 16), normal strobe at 20
        for (int i = 0; i <= 23; i++) begin
            drive(i % 4 == 0);
            check($sformatf("p4_locked_%0d", i), 32'(locked), 32'(i >= 16));
            check($sformatf("p4_error_%0d", i), 32'(error), 32'd0);
            check($sformatf("p4_period_%0d", i), 32'(period), (i >= 16) ? 32'd4 : 32'd0);
            check($sformatf("p4_mexp_%0d", i), 32'(mask_expected),
                  32'(i >= 16 && i % 4 == 3));
        end

        // Missing strobe at 24 -> IDLE; strobes at 28..44 relock with period 4
        for (int i = 24; i <= 44; i++) begin
            drive(i % 4 == 0 && i != 24);
            check($sformatf("miss_error_%0d", i), 32'(error), 32'(i == 24));
            check($sformatf("miss_locked_%0d", i), 32'(locked), 32'(i >= 44));
            check($sformatf("miss_period_%0d", i), 32'(period), 32'd4);
        end

        // Lock at period 5, early strobe at gap 3, relock at period 3 after 3 strobes
        do_reset();
        for (int i = 0; i <= 35; i++) begin
            m = (i <= 20) ? (i % 5 == 0) : (i >= 23 && (i - 23) % 3 == 0);
            drive(m);
            check($sformatf("early_error_%0d", i), 32'(error), 32'(i == 23));
            check($sformatf("early_locked_%0d", i), 32'(locked),
                  32'((i >= 20 && i < 23) || i >= 32));
            check($sformatf("early_period_%0d", i), 32'(period),
                  (i < 20) ? 32'd0 : (i < 32) ? 32'd5 : 32'd3);
            check($sformatf("early_mexp_%0d", i), 32'(mask_expected), 32'(i == 34));
        end

        // Asynchronous reset while locked, checked before any clock edge
        @(negedge clk_in);
        rst = 1'b1;
        #1;
        check("async_locked", 32'(locked), 32'd0);
        check("async_period", 32'(period), 32'd0);
        check("async_error", 32'(error), 32'd0);
        check("async_mexp", 32'(mask_expected), 32'd0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;

        // Constant mask: period 1, locked on 5th edge, never an error
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1);
            check($sformatf("p1_locked_%0d", i), 32'(locked), 32'(i >= 4));
            check($sformatf("p1_period_%0d", i), 32'(period), (i >= 4) ? 32'd1 : 32'd0);
            check($sformatf("p1_mexp_%0d", i), 32'(mask_expected), 32'(i >= 4));
            check($sformatf("p1_error_%0d", i), 32'(error), 32'd0);
        end

        // ACQUIRE timeout when cnt reaches 64; IDLE saturation is silent;
        // a gap of exactly 64 is still accepted afterwards
        do_reset();
        for (int i = 0; i <= 229; i++) begin
            drive(i == 0 || i == 101 || i == 165 || i == 229);
            check($sformatf("tmo_error_%0d", i), 32'(error), 32'(i == 64));
            check($sformatf("tmo_locked_%0d", i), 32'(locked), 32'd0);
        end

`ifdef CLK_MASK_MONITOR_ERRCNT_EN
        // Each 1,1,1,1,1,0 round locks at period 1 then misses one strobe
        do_reset();
        check("ec_reset", 32'(err_count), 32'd0);
        for (int n = 1; n <= 300; n++) begin
            for (int k = 0; k < 5; k++) drive(1'b1);
            drive(1'b0);
            if (n == 100) check("ec_100", 32'(err_count), 32'd100);
            if (n == 255) check("ec_255", 32'(err_count), 32'd255);
        end
        check("ec_300", 32'(err_count), 32'd255);
        for (int k = 0; k < 5; k++) drive(1'b1);
        check("ec_relock", 32'(err_count), 32'd255);
        @(negedge clk_in);
        rst = 1'b1;
        #1;
        check("ec_async", 32'(err_count), 32'd0);
        check("ec_async_locked", 32'(locked), 32'd0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
